register_file_responder: RTL
============================

Name: register_file_responder

Overview:
- Architectural register file: 16 × 32-bit general registers. It is the receiving end of the stage-2 write interface (register writes, immediate writes, ALU-result writes).
- Provides two combinational read ports to the decode/stage-1 side.
- Keeps a per-register pending-write scoreboard so stage 1 can stall on read-after-write hazards until stage 2 retires the write.

Parameters:
- PEND_W, 2, width of each per-register pending-write counter; saturates at 2^PEND_W-1.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (sampled on the rising clock edge; 0 = reset).
- write  input  1  stage-2 register write strobe.
- write_index  input  4  destination register for write or write_immediate.
- write_data  input  32 (t_reg)  load data; used when write=1 and alu_cycle=0.
- alu_cycle  input  1  when 1 together with write=1, write data comes from alu_result.
- alu_result  input  32 (t_reg)  latched ALU result from stage 2.
- write_immediate  input  1  immediate write strobe.
- write_immediate_data  input  16  immediate value.
- write_immediate_type  input  2 (t_immediate_type)  immediate merge mode.
- issue  input  1  stage 1 has issued an instruction that writes issue_index.
- issue_index  input  4  destination register of the issued instruction.
- read_index_a  input  4  read port A select.
- read_index_b  input  4  read port B select.
- read_data_a  output  32 (t_reg)  contents of register read_index_a.
- read_data_b  output  32 (t_reg)  contents of register read_index_b.
- stall  output  1  a read index has a pending write not retiring this cycle.
- pending_overflow  output  1  sticky; set when issue hits a saturated counter.

Behaviour:
- Reset (reset=0 at a clock edge): all 16 registers = 32'h0, all pending counters = 0, pending_overflow = 0. The read outputs therefore show 0 and stall = 0 from the following cycle.
- Writes take effect at the clock edge; the new value is visible on the read ports the cycle after the edge.
- Write source priority:
  - write=1: data = alu_cycle ? alu_result : write_data.
  - else write_immediate=1: immediate merge, using the current register value (read-modify-write within the same edge).
  - write and write_immediate both 1: write wins; the immediate is dropped.
- Immediate merge by write_immediate_type:
  - IT_UNSIGNED: {16'h0, imm}.
  - IT_SIGNED: {{16{imm[15]}}, imm}.
  - IT_TOP: {imm, old[15:0]}.
  - IT_BOTTOM: {old[31:16], imm}.
- Retire: either write or write_immediate retires one pending write on write_index.
- Pending counter update, per register r:
  - inc = issue && issue_index==r; dec = retire && write_index==r.
  - inc only: +1. If already at maximum, the counter holds and pending_overflow sets.
  - dec only: -1. At 0 the counter holds at 0 (a write without an issue is legal, e.g. after reset).
  - inc and dec together: unchanged.
- stall (combinational) = any port p in {A, B} whose counter[read_index_p] ≠ 0, unless that counter is 1 and it retires this cycle on the same index. The exception only applies with BYPASS_EN; without it, stall stays asserted for that cycle.
- stall does not block writes or issue. Stage 1 must not assert issue while stall is 1; if it does, the issue is still counted.
- pending_overflow is cleared only by reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: each read port forwards the value being written this cycle (the same merged value selected above) when read_index matches write_index and a retire occurs. The stall exception above applies.
- Undefined: read ports show flop contents only; stall does not consider same-cycle retires.

Decomposition:
- Shared package registers.vh gains:
  - constants NUM_REGS=16 and REG_INDEX_W=4;
  - the merge-function definition next to t_immediate_type (IT_UNSIGNED, IT_SIGNED, IT_TOP, IT_BOTTOM);
  - t_reg stays where it is.
- One natural sub-module: reg_pending_counter, a single saturating up/down counter with an overflow flag, instantiated 16 times.
- Immediate merge and read muxes stay inline.

Test Plan:
- Reset then read all indices: read_data = 0, stall = 0. Assert reset mid-write (write=1, idx 3, data 32'hDEADBEEF): r3 stays 0.
- Immediate merge:
  - LOADI IT_UNSIGNED 16'h8001 into r5 → r5 = 32'h00008001.
  - IT_SIGNED 16'h8001 → 32'hFFFF8001.
  - Then IT_TOP 16'h1234 → 32'h12348001.
  - Then IT_BOTTOM 16'h5678 → 32'h12345678.
- Write source select:
  - write=1, alu_cycle=1, alu_result=32'hA5A5A5A5, write_data=32'h1, idx 7 → r7 = 32'hA5A5A5A5.
  - Same cycle write_immediate=1 as well → immediate ignored.
- Hazard: issue idx 2 (cycle 0), read_index_a=2 → stall=1 from cycle 1. Write idx 2 at cycle 3 → stall=1 in cycle 3 without bypass, 0 with REGFILE_BYPASS_EN (read_data_a = new value in cycle 3). stall=0 in cycle 4 either way.
- Counter corners:
  - Issue idx 9 three times, with issue and retire together once (counter stays at 2).
  - Two retires → counter 0, stall clear.
  - Four issues with no retire → counter holds at 3 and pending_overflow=1 until reset.

Source files
------------

// File: rtl/register_file_responder_pkg.sv
// Shared register-file types: register word, immediate merge modes and the merge rule.
// Pure declarations; no state, no latency.
package register_file_responder_pkg;

  localparam int NUM_REGS    = 16;
  localparam int REG_INDEX_W = 4;

  typedef logic [31:0] t_reg;

  typedef enum logic [1:0] {
    IT_UNSIGNED = 2'd0,
    IT_SIGNED   = 2'd1,
    IT_TOP      = 2'd2,
    IT_BOTTOM   = 2'd3
  } t_immediate_type;

  // TOP/BOTTOM keep the other half of the current register value.
  function automatic t_reg merge_immediate(input t_immediate_type it,
                                           input logic [15:0]     imm,
                                           input t_reg            old);
    merge_immediate = {16'h0, imm};
    case (it)
      IT_UNSIGNED: merge_immediate = {16'h0, imm};
      IT_SIGNED:   merge_immediate = {{16{imm[15]}}, imm};
      IT_TOP:      merge_immediate = {imm, old[15:0]};
      IT_BOTTOM:   merge_immediate = {old[31:16], imm};
    endcase
  endfunction

endpackage

// File: rtl/register_file_responder_reg_pending_counter.sv
// Saturating up/down pending-write counter with sticky overflow; updates one cycle after inc/dec.
// No backpressure: inc at max holds and flags overflow, dec at zero holds.
module reg_pending_counter #(
  parameter int PEND_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [PEND_W-1:0] o_count,
  output logic              o_overflow
);

  logic [PEND_W-1:0] r_count;
  logic              r_overflow;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (i_inc && !i_dec) begin
      if (r_count == {PEND_W{1'b1}})
        r_overflow <= 1'b1;
      else
        r_count <= r_count + PEND_W'(1);
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      r_count <= r_count - PEND_W'(1);
    end
  end

  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/register_file_responder.sv
// 16x32 register file with two combinational read ports and a pending-write scoreboard; writes visible next cycle.
// stall never blocks writes/issue; build with REGFILE_BYPASS_EN to forward same-cycle retires to the read ports.
module register_file_responder
  import register_file_responder_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   write,
  input  logic [REG_INDEX_W-1:0] write_index,
  input  t_reg                   write_data,
  input  logic                   alu_cycle,
  input  t_reg                   alu_result,
  input  logic                   write_immediate,
  input  logic [15:0]            write_immediate_data,
  input  t_immediate_type        write_immediate_type,
  input  logic                   issue,
  input  logic [REG_INDEX_W-1:0] issue_index,
  input  logic [REG_INDEX_W-1:0] read_index_a,
  input  logic [REG_INDEX_W-1:0] read_index_b,
  output t_reg                   read_data_a,
  output t_reg                   read_data_b,
  output logic                   stall,
  output logic                   pending_overflow
);

  t_reg              r_regs [NUM_REGS];
  logic [PEND_W-1:0] w_count [NUM_REGS];
  logic [NUM_REGS-1:0] w_overflow;

  logic w_retire;
  t_reg w_wval;
  logic w_busy_a;
  logic w_busy_b;

  assign w_retire = write | write_immediate;

  // A plain write beats an immediate presented in the same cycle.
  always_comb begin
    w_wval = '0;
    if (write)
      w_wval = alu_cycle ? alu_result : write_data;
    else
      w_wval = merge_immediate(write_immediate_type, write_immediate_data,
                               r_regs[write_index]);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_retire) begin
      r_regs[write_index] <= w_wval;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
    reg_pending_counter #(.PEND_W(PEND_W)) u_cnt (
      .clock      (clock),
      .reset      (reset),
      .i_inc      (issue && (issue_index == REG_INDEX_W'(g))),
      .i_dec      (w_retire && (write_index == REG_INDEX_W'(g))),
      .o_count    (w_count[g]),
      .o_overflow (w_overflow[g])
    );
  end

  assign pending_overflow = |w_overflow;

`ifdef REGFILE_BYPASS_EN
  logic w_hit_a;
  logic w_hit_b;

  // The last outstanding write retiring now no longer needs to hold stage 1.
  always_comb begin
    w_hit_a     = w_retire && (write_index == read_index_a);
    w_hit_b     = w_retire && (write_index == read_index_b);
    read_data_a = w_hit_a ? w_wval : r_regs[read_index_a];
    read_data_b = w_hit_b ? w_wval : r_regs[read_index_b];
    w_busy_a    = (w_count[read_index_a] != '0) &&
                  !(w_hit_a && (w_count[read_index_a] == PEND_W'(1)));
    w_busy_b    = (w_count[read_index_b] != '0) &&
                  !(w_hit_b && (w_count[read_index_b] == PEND_W'(1)));
  end
`else
  always_comb begin
    read_data_a = r_regs[read_index_a];
    read_data_b = r_regs[read_index_b];
    w_busy_a    = (w_count[read_index_a] != '0);
    w_busy_b    = (w_count[read_index_b] != '0);
  end
`endif

  assign stall = w_busy_a | w_busy_b;

endmodule
